// File: rtl/event_trigger_pkg.sv
// event_trigger_pkg: shared defaults and types for the event-trigger scheduler
package event_trigger_pkg;
  localparam int DEF_DLY_W = 4;
  localparam int DEF_CNT_W = 8;
  typedef logic [DEF_DLY_W-1:0] delay_t;
endpackage

// File: rtl/event_trigger_fifo.sv
// event_trigger_fifo: synchronous request FIFO with same-edge push and pop
module event_trigger_fifo import event_trigger_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = DEF_DLY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic          do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd + AW'(do_pop);
      wr    <= wr + AW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/event_trigger_sched.sv
// event_trigger_sched: queued delayed triggers firing one-cycle fire/wake pulses
module event_trigger_sched import event_trigger_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int DLY_W   = DEF_DLY_W,
  parameter int WAITERS = 4,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [DLY_W-1:0]           req_delay,
  output logic                       req_ready,
  input  logic [WAITERS-1:0]         arm,
  output logic [WAITERS-1:0]         wake,
  output logic                       fire,
  output logic [CNT_W-1:0]           fire_count,
  output logic [$clog2(DEPTH+2)-1:0] pending
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH+2);
  logic               busy, busy_n, fire_edge, push, pop, full, empty;
  logic [DLY_W-1:0]   cnt, head;
  logic [CW-1:0]      count;
  logic [WAITERS-1:0] armed;
  event_trigger_fifo #(.DEPTH(DEPTH), .W(DLY_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(req_delay),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign fire_edge = busy && cnt == '0;
  assign pop       = !empty && (!busy || fire_edge);
  assign busy_n    = pop || (busy && !fire_edge);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      cnt        <= '0;
      armed      <= '0;
      wake       <= '0;
      fire       <= 1'b0;
      fire_count <= '0;
      pending    <= '0;
    end else begin
      busy       <= busy_n;
      cnt        <= pop ? head : (busy && cnt != '0) ? cnt - 1'b1 : cnt;
      fire       <= fire_edge;
      wake       <= fire_edge ? armed : '0;
      // arms sampled on the fire edge belong to the next trigger
      armed      <= fire_edge ? arm : armed | arm;
      fire_count <= fire_count + CNT_W'(fire_edge);
      pending    <= PW'(count) + PW'(push) - PW'(pop) + PW'(busy_n);
    end
  end
endmodule

// File: tb/tb_event_trigger_sched.sv
// tb_event_trigger_sched: table-driven vectors plus multi-cycle corner sequences
module tb_event_trigger_sched;
  import event_trigger_pkg::*;
  logic       clk, rst, req_valid, req_ready, fire;
  delay_t     req_delay;
  logic [3:0] arm, wake;
  logic [7:0] fire_count;
  logic [2:0] pending;
  int passed = 0, total = 0;

  event_trigger_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_delay(req_delay),
    .req_ready(req_ready), .arm(arm), .wake(wake), .fire(fire),
    .fire_count(fire_count), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, v;
    logic [3:0] d, a;
    logic       f;
    logic [3:0] w;
    logic [7:0] fc;
    logic [2:0] p;
    logic       rdy;
  } vec_t;
  vec_t vec [31];

  function automatic vec_t mk(logic r, v, logic [3:0] d, a, logic f, logic [3:0] w,
                              logic [7:0] fc, logic [2:0] p, logic rdy);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.a = a; t.f = f; t.w = w; t.fc = fc; t.p = p; t.rdy = rdy;
    return t;
  endfunction

  task automatic step(input logic r, v, input logic [3:0] d, a);
    rst = r; req_valid = v; req_delay = d; arm = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [31:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", n, act, exp);
    else passed++;
  endtask

  initial begin
    logic [3:0] acc;
    int nf;
    // single trigger, then arm-on-fire-edge
    vec[0]  = mk(1,0,0,0, 0,0,0,0,1);
    vec[1]  = mk(0,0,0,5, 0,0,0,0,1);
    vec[2]  = mk(0,1,3,0, 0,0,0,1,1);
    vec[3]  = mk(0,0,0,0, 0,0,0,1,1);
    vec[4]  = mk(0,0,0,0, 0,0,0,1,1);
    vec[5]  = mk(0,0,0,0, 0,0,0,1,1);
    vec[6]  = mk(0,0,0,0, 0,0,0,1,1);
    vec[7]  = mk(0,0,0,0, 1,5,1,0,1);
    vec[8]  = mk(0,0,0,0, 0,0,1,0,1);
    vec[9]  = mk(0,1,0,0, 0,0,1,1,1);
    vec[10] = mk(0,0,0,0, 0,0,1,1,1);
    vec[11] = mk(0,0,0,2, 1,0,2,0,1);
    vec[12] = mk(0,1,0,0, 0,0,2,1,1);
    vec[13] = mk(0,0,0,0, 0,0,2,1,1);
    vec[14] = mk(0,0,0,0, 1,2,3,0,1);
    vec[15] = mk(0,0,0,0, 0,0,3,0,1);
    // long blocker, four delay-0 behind it fill the FIFO, held request not taken
    vec[16] = mk(1,0,0,0, 0,0,0,0,1);
    vec[17] = mk(0,1,6,0, 0,0,0,1,1);
    vec[18] = mk(0,1,0,0, 0,0,0,2,1);
    vec[19] = mk(0,1,0,0, 0,0,0,3,1);
    vec[20] = mk(0,1,0,0, 0,0,0,4,1);
    vec[21] = mk(0,1,0,0, 0,0,0,5,0);
    vec[22] = mk(0,1,0,0, 0,0,0,5,0);
    vec[23] = mk(0,1,0,0, 0,0,0,5,0);
    vec[24] = mk(0,0,0,0, 0,0,0,5,0);
    vec[25] = mk(0,0,0,0, 1,0,1,4,1);
    vec[26] = mk(0,0,0,0, 1,0,2,3,1);
    vec[27] = mk(0,0,0,0, 1,0,3,2,1);
    vec[28] = mk(0,0,0,0, 1,0,4,1,1);
    vec[29] = mk(0,0,0,0, 1,0,5,0,1);
    vec[30] = mk(0,0,0,0, 0,0,5,0,1);

    rst = 1'b1; req_valid = 1'b0; req_delay = '0; arm = '0;
    @(negedge clk);
    for (int i = 0; i < 31; i++) begin
      step(vec[i].r, vec[i].v, vec[i].d, vec[i].a);
      chk($sformatf("v%0d_fire", i), fire, vec[i].f);
      chk($sformatf("v%0d_wake", i), wake, vec[i].w);
      chk($sformatf("v%0d_fire_count", i), fire_count, vec[i].fc);
      chk($sformatf("v%0d_pending", i), pending, vec[i].p);
      chk($sformatf("v%0d_req_ready", i), req_ready, vec[i].rdy);
    end

    // arm with nothing pending stays armed, woken by a later trigger
    step(1,0,0,0);
    step(0,0,0,1);
    acc = '0;
    nf = 0;
    for (int i = 0; i < 20; i++) begin
      step(0,0,0,0);
      acc |= wake;
      nf += int'(fire);
    end
    chk("idle_wake", acc, 0);
    chk("idle_fire", nf, 0);
    step(0,1,0,0);
    step(0,0,0,0);
    step(0,0,0,0);
    chk("held_arm_fire", fire, 1);
    chk("held_arm_wake", wake, 1);

    // fire_count wraps after 256 triggers
    step(1,0,0,0);
    nf = 0;
    for (int i = 0; i < 400 && nf < 256; i++) begin
      step(0,1,0,0);
      if (fire) begin
        nf++;
        if (nf == 255) chk("wrap_255", fire_count, 255);
        if (nf == 256) chk("wrap_0", fire_count, 0);
      end
    end
    chk("wrap_fires", nf, 256);
    for (int i = 0; i < 5; i++) step(0,0,0,0);

    // reset mid-countdown drops queued work and armed waiters
    step(1,0,0,0);
    step(0,1,5,4'hf);
    step(0,1,5,0);
    step(0,1,5,0);
    chk("pre_rst_pending", pending, 3);
    step(0,0,0,0);
    step(1,0,0,0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", req_ready, 1);
    acc = '0;
    nf = 0;
    for (int i = 0; i < 20; i++) begin
      step(0,0,0,0);
      acc |= wake;
      nf += int'(fire);
    end
    chk("rst_no_fire", nf, 0);
    chk("rst_no_wake", acc, 0);
    step(0,1,0,0);
    step(0,0,0,0);
    step(0,0,0,0);
    chk("rst_after_fire", fire, 1);
    chk("rst_armed_cleared", wake, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
